// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences each instruction
// through shared memory and ALU, with watchdog and traps.
module multicycle_control #(
  parameter int OPCODE_WIDTH = 6,
  parameter int ALU_OP_WIDTH = 3,
  parameter int MEM_TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic                    mem_ready_i,
  input  logic                    stall_i,
  output logic                    pc_write_o,
  output logic                    ir_write_o,
  output logic                    i_or_d_o,
  output logic                    mem_read_o,
  output logic                    mem_write_o,
  output logic                    reg_write_o,
  output logic                    reg_dst_o,
  output logic                    mem_to_reg_o,
  output logic                    link_o,
  output logic                    alu_src_a_o,
  output logic [1:0]              alu_src_b_o,
  output logic [1:0]              pc_src_o,
  output logic                    branch_eq_o,
  output logic                    branch_ne_o,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic [3:0]              state_o,
  output logic                    illegal_o,
  output logic                    timeout_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_TRAP      = 4'd10
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam int CW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [CW-1:0] LIM_M1 =
    CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit WD_EN = (MEM_TIMEOUT > 0);

  state_e        state_q, state_d;
  logic [5:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ill_q, ill_d;
  logic          tmo_q, tmo_d;

  logic [5:0] op6;
  logic       hi_ok;
  logic       waiting;
  logic       wd_hit;
  logic [2:0] alu3;

  assign op6     = opcode_i[5:0];
  assign hi_ok   = (opcode_i >> 6) == '0;
  assign waiting = (state_q == S_FETCH)
                || (state_q == S_MEM_READ)
                || (state_q == S_MEM_WRITE);
  assign wd_hit  = WD_EN && waiting && !mem_ready_i
                && (cnt_q == LIM_M1);

  // State, latched opcode, watchdog and sticky trap flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next state; everything holds while stalled
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    tmo_d   = tmo_q;
    if (!stall_i) begin
      unique case (state_q)
        S_FETCH: begin
          if (mem_ready_i) begin
            state_d = S_DECODE;
          end else if (wd_hit) begin
            state_d = S_TRAP;
            tmo_d   = 1'b1;
          end
        end
        S_DECODE: begin
          op_d = op6;
          if (!hi_ok) begin
            state_d = S_TRAP;
            ill_d   = 1'b1;
          end else begin
            case (op6)
              OP_LW, OP_SW:
                state_d = S_MEM_ADDR;
              OP_R, OP_ADDI, OP_LUI,
              OP_ORI, OP_ANDI:
                state_d = S_EXECUTE;
              OP_BEQ, OP_BNE:
                state_d = S_BRANCH;
              OP_J, OP_JAL:
                state_d = S_JUMP;
              default: begin
                state_d = S_TRAP;
                ill_d   = 1'b1;
              end
            endcase
          end
        end
        S_MEM_ADDR: begin
          state_d = (op_q == OP_SW) ? S_MEM_WRITE
                                    : S_MEM_READ;
        end
        S_MEM_READ: begin
          if (mem_ready_i) begin
            state_d = S_MEM_WB;
          end else if (wd_hit) begin
            state_d = S_TRAP;
            tmo_d   = 1'b1;
          end
        end
        S_MEM_WRITE: begin
          if (mem_ready_i) begin
            state_d = S_FETCH;
          end else if (wd_hit) begin
            state_d = S_TRAP;
            tmo_d   = 1'b1;
          end
        end
        S_EXECUTE: state_d = S_ALU_WB;
        S_MEM_WB,
        S_ALU_WB,
        S_BRANCH,
        S_JUMP:    state_d = S_FETCH;
        S_TRAP:    state_d = S_TRAP;
        default:   state_d = S_TRAP;
      endcase
      if (state_d != state_q) begin
        cnt_d = '0;
      end else if (waiting && !mem_ready_i) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Moore outputs, strobes gated by stall and reset
  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    link_o       = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    pc_src_o     = 2'b00;
    branch_eq_o  = 1'b0;
    branch_ne_o  = 1'b0;
    alu3         = 3'b000;
    unique case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        alu3        = 3'b100;
        pc_write_o  = mem_ready_i;
        ir_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        alu3        = 3'b100;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu3        = 3'b101;
      end
      S_MEM_READ: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        case (op_q)
          OP_R: begin
            alu_src_b_o = 2'b00;
            alu3        = 3'b111;
          end
          OP_LUI:  alu3 = 3'b001;
          OP_ORI:  alu3 = 3'b010;
          OP_ANDI: alu3 = 3'b011;
          default: alu3 = 3'b100;
        endcase
      end
      S_ALU_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = (op_q == OP_R);
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu3        = 3'b110;
        pc_src_o    = 2'b01;
        branch_eq_o = (op_q == OP_BEQ);
        branch_ne_o = (op_q == OP_BNE);
      end
      S_JUMP: begin
        pc_write_o  = 1'b1;
        pc_src_o    = 2'b10;
        reg_write_o = (op_q == OP_JAL);
        link_o      = (op_q == OP_JAL);
      end
      default: begin
      end
    endcase
    if (stall_i || reset) begin
      pc_write_o  = 1'b0;
      ir_write_o  = 1'b0;
      reg_write_o = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      branch_eq_o = 1'b0;
      branch_ne_o = 1'b0;
    end
  end

  assign alu_op_o  = ALU_OP_WIDTH'(alu3);
  assign state_o   = state_q;
  assign illegal_o = ill_q;
  assign timeout_o = tmo_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed
// instruction sequences, per-cycle expected outputs.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, iord, mrd, mwr;
    logic       rw, rdst, m2r, lnk, srca;
    logic [1:0] srcb, pcsrc;
    logic       beq, bne;
    logic [2:0] aop;
    logic       ill, tmo;
  } obs_t;

  localparam logic [3:0] F  = 4'd0, D  = 4'd1;
  localparam logic [3:0] MA = 4'd2, MR = 4'd3;
  localparam logic [3:0] MB = 4'd4, MW = 4'd5;
  localparam logic [3:0] EX = 4'd6, AW = 4'd7;
  localparam logic [3:0] BR = 4'd8, JP = 4'd9;
  localparam logic [3:0] TR = 4'd10;
  localparam logic [5:0] XX = 6'h3f;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode_i;
  logic       mem_ready_i, stall_i;
  logic       pc_write_o, ir_write_o, i_or_d_o;
  logic       mem_read_o, mem_write_o, reg_write_o;
  logic       reg_dst_o, mem_to_reg_o, link_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o, pc_src_o;
  logic       branch_eq_o, branch_ne_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;
  logic       illegal_o, timeout_o;

  int   n_run  = 0;
  int   n_fail = 0;
  logic e_ill  = 1'b0;
  logic e_tmo  = 1'b0;
  obs_t  exp_q[$];
  string nm_q[$];

  always #5 clk = ~clk;

  multicycle_control #(
    .OPCODE_WIDTH(6),
    .ALU_OP_WIDTH(3),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode_i    (opcode_i),
    .mem_ready_i (mem_ready_i),
    .stall_i     (stall_i),
    .pc_write_o  (pc_write_o),
    .ir_write_o  (ir_write_o),
    .i_or_d_o    (i_or_d_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .reg_write_o (reg_write_o),
    .reg_dst_o   (reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o),
    .link_o      (link_o),
    .alu_src_a_o (alu_src_a_o),
    .alu_src_b_o (alu_src_b_o),
    .pc_src_o    (pc_src_o),
    .branch_eq_o (branch_eq_o),
    .branch_ne_o (branch_ne_o),
    .alu_op_o    (alu_op_o),
    .state_o     (state_o),
    .illegal_o   (illegal_o),
    .timeout_o   (timeout_o)
  );

  function automatic obs_t model(
    input logic [3:0] st,
    input logic [5:0] op,
    input logic rdy, stl, rst
  );
    obs_t o;
    o     = '0;
    o.st  = st;
    o.ill = e_ill;
    o.tmo = e_tmo;
    case (st)
      F: begin
        o.mrd  = 1'b1;
        o.srcb = 2'b01;
        o.aop  = 3'b100;
        o.pcw  = rdy;
        o.irw  = rdy;
      end
      D: begin
        o.srcb = 2'b11;
        o.aop  = 3'b100;
      end
      MA: begin
        o.srca = 1'b1;
        o.srcb = 2'b10;
        o.aop  = 3'b101;
      end
      MR: begin
        o.mrd  = 1'b1;
        o.iord = 1'b1;
      end
      MB: begin
        o.rw  = 1'b1;
        o.m2r = 1'b1;
      end
      MW: begin
        o.mwr  = 1'b1;
        o.iord = 1'b1;
      end
      EX: begin
        o.srca = 1'b1;
        o.srcb = (op == 6'h00) ? 2'b00 : 2'b10;
        case (op)
          6'h00:   o.aop = 3'b111;
          6'h0f:   o.aop = 3'b001;
          6'h0d:   o.aop = 3'b010;
          6'h0c:   o.aop = 3'b011;
          default: o.aop = 3'b100;
        endcase
      end
      AW: begin
        o.rw   = 1'b1;
        o.rdst = (op == 6'h00);
      end
      BR: begin
        o.srca  = 1'b1;
        o.aop   = 3'b110;
        o.pcsrc = 2'b01;
        o.beq   = (op == 6'h04);
        o.bne   = (op == 6'h05);
      end
      JP: begin
        o.pcw   = 1'b1;
        o.pcsrc = 2'b10;
        o.rw    = (op == 6'h03);
        o.lnk   = (op == 6'h03);
      end
      default: begin
      end
    endcase
    if (stl || rst) begin
      o.pcw = 1'b0;
      o.irw = 1'b0;
      o.rw  = 1'b0;
      o.mrd = 1'b0;
      o.mwr = 1'b0;
      o.beq = 1'b0;
      o.bne = 1'b0;
    end
    return o;
  endfunction

  task automatic cyc(
    input string nm,
    input logic r, rd, s,
    input logic [5:0] opi,
    input logic [3:0] est,
    input logic [5:0] eop
  );
    reset       = r;
    mem_ready_i = rd;
    stall_i     = s;
    opcode_i    = opi;
    exp_q.push_back(model(est, eop, rd, s, r));
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop expected snapshot, compare mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  a, e;
      string nm;
      e = exp_q.pop_front();
      nm = nm_q.pop_front();
      a = '{state_o, pc_write_o, ir_write_o,
            i_or_d_o, mem_read_o, mem_write_o,
            reg_write_o, reg_dst_o, mem_to_reg_o,
            link_o, alu_src_a_o, alu_src_b_o,
            pc_src_o, branch_eq_o, branch_ne_o,
            alu_op_o, illegal_o, timeout_o};
      n_run++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", nm, a, e);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    mem_ready_i = 1'b1;
    stall_i     = 1'b0;
    opcode_i    = XX;
    @(posedge clk);
    #1;
    cyc("rst", 1, 1, 0, XX, F, 0);
    // ADDI
    cyc("addi_f", 0, 1, 0, XX, F, 0);
    cyc("addi_d", 0, 1, 0, 6'h08, D, 0);
    cyc("addi_ex", 0, 1, 0, XX, EX, 6'h08);
    cyc("addi_wb", 0, 1, 0, XX, AW, 6'h08);
    // LW with 3 wait cycles
    cyc("lw_f", 0, 1, 0, XX, F, 0);
    cyc("lw_d", 0, 1, 0, 6'h23, D, 0);
    cyc("lw_ma", 0, 1, 0, XX, MA, 6'h23);
    for (int i = 0; i < 3; i++)
      cyc("lw_mrw", 0, 0, 0, XX, MR, 6'h23);
    cyc("lw_mr", 0, 1, 0, XX, MR, 6'h23);
    cyc("lw_wb", 0, 1, 0, XX, MB, 6'h23);
    // SW
    cyc("sw_f", 0, 1, 0, XX, F, 0);
    cyc("sw_d", 0, 1, 0, 6'h2b, D, 0);
    cyc("sw_ma", 0, 1, 0, XX, MA, 6'h2b);
    cyc("sw_mw", 0, 1, 0, XX, MW, 6'h2b);
    // BEQ, BNE
    cyc("beq_f", 0, 1, 0, XX, F, 0);
    cyc("beq_d", 0, 1, 0, 6'h04, D, 0);
    cyc("beq_br", 0, 1, 0, XX, BR, 6'h04);
    cyc("bne_f", 0, 1, 0, XX, F, 0);
    cyc("bne_d", 0, 1, 0, 6'h05, D, 0);
    cyc("bne_br", 0, 1, 0, XX, BR, 6'h05);
    // J, then JAL after a stalled fetch
    cyc("j_f", 0, 1, 0, XX, F, 0);
    cyc("j_d", 0, 1, 0, 6'h02, D, 0);
    cyc("j_jp", 0, 1, 0, XX, JP, 6'h02);
    cyc("jal_fs", 0, 1, 1, XX, F, 0);
    cyc("jal_f", 0, 1, 0, XX, F, 0);
    cyc("jal_d", 0, 1, 0, 6'h03, D, 0);
    cyc("jal_jp", 0, 1, 0, XX, JP, 6'h03);
    // R-type with 2 stall cycles in EXECUTE
    cyc("r_f", 0, 1, 0, XX, F, 0);
    cyc("r_d", 0, 1, 0, 6'h00, D, 0);
    cyc("r_exs", 0, 1, 1, XX, EX, 6'h00);
    cyc("r_exs", 0, 1, 1, XX, EX, 6'h00);
    cyc("r_ex", 0, 1, 0, XX, EX, 6'h00);
    cyc("r_wbs", 0, 1, 1, XX, AW, 6'h00);
    cyc("r_wb", 0, 1, 0, XX, AW, 6'h00);
    // SW aborted by reset in MEM_WRITE
    cyc("swr_f", 0, 1, 0, XX, F, 0);
    cyc("swr_d", 0, 1, 0, 6'h2b, D, 0);
    cyc("swr_ma", 0, 1, 0, XX, MA, 6'h2b);
    cyc("swr_mw", 1, 1, 0, XX, MW, 6'h2b);
    // Ready on 4th fetch wait cycle, no trap
    for (int i = 0; i < 3; i++)
      cyc("wd_fw", 0, 0, 0, XX, F, 0);
    cyc("wd_f4", 0, 1, 0, XX, F, 0);
    // Illegal opcode
    cyc("ill_d", 0, 1, 0, 6'h3f, D, 0);
    e_ill = 1'b1;
    for (int i = 0; i < 20; i++)
      cyc("ill_tr", 0, 1'(i), 0, XX, TR, 0);
    cyc("ill_rst", 1, 0, 0, XX, TR, 0);
    e_ill = 1'b0;
    // Watchdog trap in FETCH
    for (int i = 0; i < 4; i++)
      cyc("to_fw", 0, 0, 0, XX, F, 0);
    e_tmo = 1'b1;
    cyc("to_tr", 0, 1, 0, XX, TR, 0);
    cyc("to_rst", 1, 1, 0, XX, TR, 0);
    e_tmo = 1'b0;
    // LUI, ORI, ANDI
    cyc("lui_f", 0, 1, 0, XX, F, 0);
    cyc("lui_d", 0, 1, 0, 6'h0f, D, 0);
    cyc("lui_ex", 0, 1, 0, XX, EX, 6'h0f);
    cyc("lui_wb", 0, 1, 0, XX, AW, 6'h0f);
    cyc("ori_f", 0, 1, 0, XX, F, 0);
    cyc("ori_d", 0, 1, 0, 6'h0d, D, 0);
    cyc("ori_ex", 0, 1, 0, XX, EX, 6'h0d);
    cyc("ori_wb", 0, 1, 0, XX, AW, 6'h0d);
    cyc("andi_f", 0, 1, 0, XX, F, 0);
    cyc("andi_d", 0, 1, 0, 6'h0c, D, 0);
    cyc("andi_ex", 0, 1, 0, XX, EX, 6'h0c);
    cyc("end_f", 0, 0, 0, XX, AW, 6'h0c);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d left want 0",
               exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multicycle control unit for the MIPS core: a Moore FSM that sequences each instruction over several cycles through one shared memory and ALU, replacing the single-cycle opcode decoder. It sits between the instruction register and the datapath multiplexers/enables. It adds a memory ready handshake, a stall input, a bus-timeout watchdog and an illegal-opcode trap.

## Interface
- `OPCODE_WIDTH`, 6, opcode field width; must be ≥ 6, opcode compared on bits [5:0], upper bits must be 0 for a legal match
- `ALU_OP_WIDTH`, 3, width of `alu_op_o`; must be ≥ 3, codes zero-extended
- `MEM_TIMEOUT`, 16, max cycles waiting on `mem_ready_i` before trap; 0 disables watchdog
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `opcode_i` in OPCODE_WIDTH: opcode from instruction register, sampled in DECODE only
- `mem_ready_i` in 1: memory completed current read/write this cycle
- `stall_i` in 1: freeze FSM for this cycle
- `pc_write_o` out 1: PC load enable (unconditional)
- `ir_write_o` out 1: instruction register load
- `i_or_d_o` out 1: memory address select, 0 = PC, 1 = ALUOut
- `mem_read_o`, `mem_write_o` out 1: memory strobes, held until `mem_ready_i`
- `reg_write_o`, `reg_dst_o`, `mem_to_reg_o`, `link_o` out 1: register file write, rd select, MDR select, write $31 with PC (JAL)
- `alu_src_a_o` out 1: 0 = PC, 1 = rs
- `alu_src_b_o` out 2: 00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
- `pc_src_o` out 2: 00 ALU result, 01 ALUOut, 10 jump target
- `branch_eq_o`, `branch_ne_o` out 1: conditional PC write qualifiers
- `alu_op_o` out ALU_OP_WIDTH: ALU function code
- `state_o` out 4: current state encoding
- `illegal_o`, `timeout_o` out 1: sticky trap flags

## Operation
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, TRAP=10.
- FETCH: `mem_read_o`=1, `i_or_d_o`=0, `alu_src_a_o`=0, `alu_src_b_o`=01, `alu_op_o`=100. Wait for `mem_ready_i`; on ready `ir_write_o`=`pc_write_o`=1, `pc_src_o`=00, go to DECODE.
- DECODE: `alu_src_b_o`=11, `alu_op_o`=100 (branch target precompute). Latch opcode internally. Dispatch: 0x23/0x2b→MEM_ADDR; 0x00, 0x08, 0x0f, 0x0d, 0x0c→EXECUTE; 0x04/0x05→BRANCH; 0x02/0x03→JUMP; other→TRAP, set `illegal_o`.
- MEM_ADDR: `alu_src_a_o`=1, `alu_src_b_o`=10, `alu_op_o`=101. LW→MEM_READ, SW→MEM_WRITE.
- MEM_READ: `mem_read_o`=1, `i_or_d_o`=1; on ready go to MEM_WB. MEM_WB: `reg_write_o`=1, `mem_to_reg_o`=1, `reg_dst_o`=0, go to FETCH.
- MEM_WRITE: `mem_write_o`=1, `i_or_d_o`=1; on ready go to FETCH.
- EXECUTE: `alu_src_a_o`=1. R: `alu_src_b_o`=00, op 111. ADDI 100, LUI 001, ORI 010, ANDI 011, all with `alu_src_b_o`=10. Go to ALU_WB.
- ALU_WB: `reg_write_o`=1, `reg_dst_o`=1 for R-type else 0, `mem_to_reg_o`=0, go to FETCH.
- BRANCH: `alu_src_a_o`=1, `alu_src_b_o`=00, `alu_op_o`=110, `pc_src_o`=01. Set `branch_eq_o` for 0x04 or `branch_ne_o` for 0x05. Go to FETCH.
- JUMP: `pc_write_o`=1, `pc_src_o`=10. JAL also drives `reg_write_o`=1 and `link_o`=1. Go to FETCH.
- TRAP: all strobes 0. Stay until reset.
- Signals not listed for a state are 0.
- Watchdog: counter cleared on entering FETCH/MEM_READ/MEM_WRITE. It increments each non-stalled cycle in which the state is waiting and ready=0. If it reaches MEM_TIMEOUT with ready still 0, go to TRAP and set `timeout_o`. Ready in the same cycle as the limit wins.
- `stall_i`=1: state, latched opcode and counter hold. `mem_ready_i` is ignored. All write/strobe outputs (`pc_write_o`, `ir_write_o`, `reg_write_o`, `mem_read_o`, `mem_write_o`, `branch_*`) are forced to 0. Mux selects and `alu_op_o` keep their state values.

## Timing
- Reset: next edge gives state FETCH, counter 0, `illegal_o`=`timeout_o`=0, latched opcode 0. While `reset`=1, all strobes are forced to 0 combinationally.
- Reset mid-instruction aborts it immediately. An asserted `mem_ready_i` is ignored.
- Outputs are combinational from state, the latched opcode and the stall/ready gating. There are no output registers.
- Cycle counts with zero-wait memory: R/I-ALU 4, LW 5, SW 4, BEQ/BNE 3, J/JAL 3. Each memory wait cycle adds 1.
- `opcode_i` is only required valid in DECODE.

## Test plan
- Reset, then ADDI (0x08) with ready always 1 -> state_o sequence 0,1,6,7,0. `alu_op_o`=100 in EXECUTE. `reg_write_o`=1 only in ALU_WB.
- LW (0x23) with ready delayed 3 cycles in MEM_READ -> 8 cycles total. `mem_read_o` is held for 4 cycles. MEM_WB shows `mem_to_reg_o`=1.
- JAL (0x03) -> JUMP asserts `pc_write_o`, `reg_write_o` and `link_o`, with `pc_src_o`=10. Back to FETCH after 3 cycles.
- Opcode 0x3f -> TRAP after DECODE. `illegal_o` latches to 1 and stays through 20 cycles. Reset clears it.
- MEM_TIMEOUT=4, ready held 0 in FETCH -> TRAP after 4 wait cycles with `timeout_o`=1. Repeat with ready on the 4th cycle -> DECODE, no trap.
- `stall_i` pulsed 2 cycles in EXECUTE, plus reset asserted in MEM_WRITE with ready=1 -> stall adds exactly 2 cycles with strobes 0. Reset gives FETCH next edge with `mem_write_o`=0.
